// File: rtl/pcie_link_status_mon_if.sv
// Signal bundle between the hard-IP status pins and pcie_link_status_mon.
// The LINK_MON_TRACE_EN build adds the trace_idx / trace_code pair.
interface pcie_link_status_mon_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CNT_W     = 16
);
    logic [4:0]           ltssm;
    logic [NUM_LANES-1:0] lane_act;
    logic                 cnt_clr;
    logic [1:0]           link_state;
    logic [4:0]           ltssm_filt;
    logic [CNT_W-1:0]     link_down_cnt;
    logic [CNT_W-1:0]     recovery_cnt;
    logic                 alive_led;
    logic                 L0_led;
    logic                 comp_led;
    logic [NUM_LANES-1:0] lane_active_led;
`ifdef LINK_MON_TRACE_EN
    logic [2:0]           trace_idx;
    logic [4:0]           trace_code;
`endif

    // Core / board side: drives the raw status, observes the monitor.
    modport master (
        output ltssm, lane_act, cnt_clr,
`ifdef LINK_MON_TRACE_EN
        output trace_idx,
        input  trace_code,
`endif
        input  link_state, ltssm_filt, link_down_cnt, recovery_cnt,
        input  alive_led, L0_led, comp_led, lane_active_led
    );

    // Monitor side.
    modport slave (
        input  ltssm, lane_act, cnt_clr,
`ifdef LINK_MON_TRACE_EN
        input  trace_idx,
        output trace_code,
`endif
        output link_state, ltssm_filt, link_down_cnt, recovery_cnt,
        output alive_led, L0_led, comp_led, lane_active_led
    );
endinterface

// File: rtl/pcie_link_status_mon.sv
// PCIe link-status monitor: LTSSM glitch filter, link FSM, event counters and LED drivers.
// Optional LINK_MON_TRACE_EN adds an 8-entry history of accepted LTSSM codes.
module pcie_link_status_mon #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned ALIVE_CNT_W = 25,
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned CNT_W       = 16,
    parameter logic [4:0]  L0_CODE     = 5'b01111,
    parameter logic [4:0]  COMPL_CODE  = 5'b00011
) (
    input logic                   clk_out_buf,
    input logic                   any_rstn,
    pcie_link_status_mon_if.slave mon
);

    localparam logic [1:0] ST_DOWN  = 2'd0;
    localparam logic [1:0] ST_TRAIN = 2'd1;
    localparam logic [1:0] ST_L0    = 2'd2;
    localparam logic [1:0] ST_COMPL = 2'd3;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

    // Reset synchroniser: asynchronous assert, release after two clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_out_buf or negedge any_rstn) begin
        if (!any_rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [4:0]           ltssm_q;
    logic [4:0]           ltssm_prev_q;
    logic [NUM_LANES-1:0] lane_act_q;
    logic [7:0]           stab_cnt_q, stab_cnt_d;
    logic [4:0]           filt_q;
    logic                 filt_load;

    // ltssm_prev_q is the sample that stab_cnt_q describes, so it is the value to accept.
    always_comb begin
        stab_cnt_d = 8'd1;
        if (ltssm_q == ltssm_prev_q) begin
            stab_cnt_d = (stab_cnt_q == STABLE_MAX) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
    end

    assign filt_load = (stab_cnt_q == STABLE_MAX) && (ltssm_prev_q != filt_q);

    always_ff @(posedge clk_out_buf or negedge rst_n) begin
        if (!rst_n) begin
            ltssm_q      <= '0;
            ltssm_prev_q <= '0;
            lane_act_q   <= '0;
            stab_cnt_q   <= '0;
            filt_q       <= '0;
        end else begin
            ltssm_q      <= mon.ltssm;
            ltssm_prev_q <= ltssm_q;
            lane_act_q   <= mon.lane_act;
            stab_cnt_q   <= stab_cnt_d;
            if (filt_load) begin
                filt_q <= ltssm_prev_q;
            end
        end
    end

    logic [1:0]       state_q, state_d;
    logic             exit_l0;
    logic             is_recovery;
    logic [CNT_W-1:0] down_cnt_q, down_cnt_d;
    logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;

    always_comb begin
        state_d = ST_TRAIN;
        if (filt_q == L0_CODE) begin
            state_d = ST_L0;
        end else if (filt_q == COMPL_CODE) begin
            state_d = ST_COMPL;
        end else if (filt_q == 5'd0) begin
            state_d = ST_DOWN;
        end
    end

    assign exit_l0     = (state_q == ST_L0) && (state_d != ST_L0);
    assign is_recovery = (filt_q[4:2] == 3'b011);

    // Clear has priority over a coincident increment; counters stick at all-ones.
    always_comb begin
        down_cnt_d = down_cnt_q;
        rec_cnt_d  = rec_cnt_q;
        if (mon.cnt_clr) begin
            down_cnt_d = '0;
            rec_cnt_d  = '0;
        end else if (exit_l0) begin
            if (is_recovery) begin
                if (rec_cnt_q != '1) begin
                    rec_cnt_d = rec_cnt_q + CNT_W'(1);
                end
            end else if (down_cnt_q != '1) begin
                down_cnt_d = down_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_out_buf or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DOWN;
            down_cnt_q <= '0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            down_cnt_q <= down_cnt_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

    logic [ALIVE_CNT_W-1:0] hb_q;
    logic                   alive_q;
    logic                   l0_led_q, l0_led_d;
    logic                   comp_led_q;
    logic [NUM_LANES-1:0]   lane_led_q;

    always_comb begin
        l0_led_d = 1'b1;
        case (state_q)
            ST_L0:    l0_led_d = 1'b0;
            ST_TRAIN: l0_led_d = ~hb_q[ALIVE_CNT_W-3];
            default:  l0_led_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_out_buf or negedge rst_n) begin
        if (!rst_n) begin
            hb_q       <= '0;
            alive_q    <= 1'b0;
            l0_led_q   <= 1'b1;
            comp_led_q <= 1'b1;
            lane_led_q <= '1;
        end else begin
            hb_q       <= hb_q + ALIVE_CNT_W'(1);
            alive_q    <= hb_q[ALIVE_CNT_W-1];
            l0_led_q   <= l0_led_d;
            comp_led_q <= (state_q != ST_COMPL);
            lane_led_q <= ~lane_act_q;
        end
    end

`ifdef LINK_MON_TRACE_EN
    logic [4:0] trace_mem_q [8];
    logic [2:0] wr_ptr_q;
    logic [2:0] rd_ptr;
    logic [4:0] trace_code_q;

    // Index 0 is the most recently accepted code.
    assign rd_ptr = wr_ptr_q - 3'd1 - mon.trace_idx;

    always_ff @(posedge clk_out_buf or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                trace_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            trace_code_q <= '0;
        end else begin
            if (filt_load) begin
                trace_mem_q[wr_ptr_q] <= ltssm_prev_q;
                wr_ptr_q              <= wr_ptr_q + 3'd1;
            end
            trace_code_q <= trace_mem_q[rd_ptr];
        end
    end

    assign mon.trace_code = trace_code_q;
`endif

    assign mon.link_state      = state_q;
    assign mon.ltssm_filt      = filt_q;
    assign mon.link_down_cnt   = down_cnt_q;
    assign mon.recovery_cnt    = rec_cnt_q;
    assign mon.alive_led       = alive_q;
    assign mon.L0_led          = l0_led_q;
    assign mon.comp_led        = comp_led_q;
    assign mon.lane_active_led = lane_led_q;

endmodule
